// File: rtl/vram_req_bridge.sv
// Buffers game-logic VRAM read/write strobes in a command FIFO and issues them
// one at a time over a req/ack handshake, returning read data through a second FIFO.
module vram_req_bridge #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int CMD_DEPTH = 4,
  parameter int RD_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              read,
  input  logic [ADDR_W-1:0] readaddr,
  output logic              wr_full,
  output logic              rd_empty,
  output logic [DATA_W-1:0] readdata,
  input  logic              rd_pop,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_drop
);

  localparam int CPW = $clog2(CMD_DEPTH);
  localparam int RPW = $clog2(RD_DEPTH);
  localparam logic [CPW:0] CMD_FULL = (CPW+1)'(CMD_DEPTH);
  localparam logic [RPW:0] RD_FULL  = (RPW+1)'(RD_DEPTH);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e state_q, state_d;

  logic              cmd_we_mem   [CMD_DEPTH];
  logic [ADDR_W-1:0] cmd_addr_mem [CMD_DEPTH];
  logic [DATA_W-1:0] cmd_data_mem [CMD_DEPTH];
  logic [CPW-1:0]    cmd_wptr_q, cmd_rptr_q;
  logic [CPW:0]      cmd_cnt_q;

  logic [DATA_W-1:0] rd_mem [RD_DEPTH];
  logic [RPW-1:0]    rd_wptr_q, rd_rptr_q;
  logic [RPW:0]      rd_cnt_q;
  // Reads accepted but not yet consumed by rd_pop (queued + in flight + buffered).
  logic [RPW:0]      rd_out_q;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              err_q;

  logic push_wr, push_rd, cmd_push, drop, rd_pop_ok;
  logic load, cmd_pop, rd_push;

  assign wr_full   = (cmd_cnt_q == CMD_FULL);
  assign rd_empty  = (rd_cnt_q == '0);
  assign push_wr   = write && !wr_full;
  assign push_rd   = read && !write && !wr_full && (rd_out_q < RD_FULL);
  assign cmd_push  = push_wr || push_rd;
  assign drop      = (write && wr_full) || (read && !push_rd);
  assign rd_pop_ok = rd_pop && !rd_empty;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    cmd_pop = 1'b0;
    rd_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_cnt_q != '0) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          cmd_pop = 1'b1;
          rd_push = !mem_we_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_wptr_q  <= '0;
      cmd_rptr_q  <= '0;
      cmd_cnt_q   <= '0;
      rd_wptr_q   <= '0;
      rd_rptr_q   <= '0;
      rd_cnt_q    <= '0;
      rd_out_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_push) cmd_wptr_q <= cmd_wptr_q + CPW'(1);
      if (cmd_pop)  cmd_rptr_q <= cmd_rptr_q + CPW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + (CPW+1)'(1);
        2'b01:   cmd_cnt_q <= cmd_cnt_q - (CPW+1)'(1);
        default: cmd_cnt_q <= cmd_cnt_q;
      endcase
      if (rd_push)   rd_wptr_q <= rd_wptr_q + RPW'(1);
      if (rd_pop_ok) rd_rptr_q <= rd_rptr_q + RPW'(1);
      case ({rd_push, rd_pop_ok})
        2'b10:   rd_cnt_q <= rd_cnt_q + (RPW+1)'(1);
        2'b01:   rd_cnt_q <= rd_cnt_q - (RPW+1)'(1);
        default: rd_cnt_q <= rd_cnt_q;
      endcase
      case ({push_rd, rd_pop_ok})
        2'b10:   rd_out_q <= rd_out_q + (RPW+1)'(1);
        2'b01:   rd_out_q <= rd_out_q - (RPW+1)'(1);
        default: rd_out_q <= rd_out_q;
      endcase
      if (load) begin
        mem_we_q    <= cmd_we_mem[cmd_rptr_q];
        mem_addr_q  <= cmd_addr_mem[cmd_rptr_q];
        mem_wdata_q <= cmd_data_mem[cmd_rptr_q];
      end
      if (drop) err_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; counts gate every use of it, and readdata is masked when empty.
  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_we_mem[cmd_wptr_q]   <= push_wr;
      cmd_addr_mem[cmd_wptr_q] <= push_wr ? writeaddr : readaddr;
      cmd_data_mem[cmd_wptr_q] <= push_wr ? writedata : '0;
    end
    if (rd_push) rd_mem[rd_wptr_q] <= mem_rdata;
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err_drop  = err_q;
  assign readdata  = rd_empty ? '0 : rd_mem[rd_rptr_q];

endmodule
